ws2812_frame_driver: RTL and testbench



---
 rtl/ws2812_frame_driver_pkg.sv | 29 ++
 rtl/ws2812_bit_encoder.sv | 56 +++++
 rtl/ws2812_frame_driver.sv | 188 ++++++++++++++++++
 tb/tb_ws2812_frame_driver.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_frame_driver_pkg.sv
// Shared types, image geometry and default 50 MHz WS2812 timing for the frame driver.
// IMG_WIDTH/IMG_HEIGHT here set the default frame size seen by ws2812_frame_driver.
package ws2812_frame_driver_pkg;

    localparam int IMG_WIDTH  = 2;
    localparam int IMG_HEIGHT = 2;

    localparam int DEF_T0H_CYC   = 20;
    localparam int DEF_T1H_CYC   = 40;
    localparam int DEF_BIT_CYC   = 63;
    localparam int DEF_LATCH_CYC = 3000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREFETCH,
        ST_SHIFT,
        ST_LATCH
    } state_t;

    // Byte offset within a pixel for transmit slot 0/1/2 (G, R, B).
    function automatic logic [1:0] grb_offset(input logic [1:0] slot);
        case (slot)
            2'd0:    return 2'd1;
            2'd1:    return 2'd0;
            default: return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Times one WS2812 bit: line high for T0H/T1H cycles, low for the rest of BIT_CYC.
// A bit_start in the last cycle of a bit chains the next bit with no gap.
module ws2812_bit_encoder
    import ws2812_frame_driver_pkg::*;
#(
    parameter int T0H_CYC = DEF_T0H_CYC,
    parameter int T1H_CYC = DEF_T1H_CYC,
    parameter int BIT_CYC = DEF_BIT_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bit_val,
    input  logic bit_start,
    output logic led_out,
    output logic bit_last
);
    localparam int CNT_W = $clog2(BIT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             act_q, act_d;
    logic [CNT_W-1:0] high_cyc;

    assign high_cyc = bit_val ? CNT_W'(T1H_CYC) : CNT_W'(T0H_CYC);
    assign bit_last = act_q && (cnt_q == CNT_LAST);
    assign led_out  = act_q && (cnt_q < high_cyc);

    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (latch).
        act_d = act_q;
        cnt_d = cnt_q;
        if (bit_start) begin
            act_d = 1'b1;
            cnt_d = '0;
        end else if (act_q) begin
            if (cnt_q == CNT_LAST) begin
                act_d = 1'b0;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use <= so every flop samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            act_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            act_q <= act_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ws2812_frame_driver.sv
// Reads a frame from a 1-cycle-latency byte buffer and streams it to a WS2812 chain, then latches.
// Build macro SERPENTINE_EN reverses the column order of odd rows (zig-zag matrix wiring).
module ws2812_frame_driver
    import ws2812_frame_driver_pkg::*;
#(
    parameter int NUM_LEDS  = IMG_WIDTH * IMG_HEIGHT,
    parameter int ADDR_W    = 16,
    parameter int T0H_CYC   = DEF_T0H_CYC,
    parameter int T1H_CYC   = DEF_T1H_CYC,
    parameter int BIT_CYC   = DEF_BIT_CYC,
    parameter int LATCH_CYC = DEF_LATCH_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [7:0]        rd_data,
    output logic              led_out
);
    localparam int LCNT_W = ($clog2(LATCH_CYC) > 12) ? $clog2(LATCH_CYC) : 12;
    localparam logic [LCNT_W-1:0] LATCH_LAST = LCNT_W'(LATCH_CYC - 1);
    localparam logic [ADDR_W-1:0] LAST_BYTE  = ADDR_W'(3 * NUM_LEDS - 1);
    localparam logic [ADDR_W-1:0] COL_LAST   = ADDR_W'(IMG_WIDTH - 1);

    state_t            state_q, state_d;
    logic              pf_q, pf_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [ADDR_W-1:0] byte_idx_q, byte_idx_d;
    logic [LCNT_W-1:0] latch_q, latch_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        next_q, next_d;
    logic              rd_req_q, rd_req_d;
    logic              rd_vld_q, rd_vld_d;
    logic [ADDR_W-1:0] f_col_q, f_col_d;
    logic [ADDR_W-1:0] f_row_q, f_row_d;
    logic [1:0]        f_slot_q, f_slot_d;

    logic              bit_start, bit_last, frame_last_bit, latch_end;
    logic [ADDR_W-1:0] phys_col, fetch_addr;

    assign frame_last_bit = bit_last && (bit_idx_q == 3'd7) && (byte_idx_q == LAST_BYTE);
    assign latch_end      = (latch_q == LATCH_LAST);

    ws2812_bit_encoder #(
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .BIT_CYC (BIT_CYC)
    ) u_enc (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_val   (shift_q[7]),
        .bit_start (bit_start),
        .led_out   (led_out),
        .bit_last  (bit_last)
    );

    // Address of the next byte to fetch, from the (row, col, GRB slot) fetch cursor.
    always_comb begin
        phys_col = f_col_q;
`ifdef SERPENTINE_EN
        if (f_row_q[0]) phys_col = COL_LAST - f_col_q;
`endif
        fetch_addr = (f_row_q * ADDR_W'(IMG_WIDTH) + phys_col) * ADDR_W'(3)
                   + ADDR_W'(grb_offset(f_slot_q));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start)          state_d = ST_PREFETCH;
            ST_PREFETCH: if (pf_q)           state_d = ST_SHIFT;
            ST_SHIFT:    if (frame_last_bit) state_d = ST_LATCH;
            ST_LATCH:    if (latch_end)      state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_LATCH) && latch_end;
        rd_en     = ((state_q == ST_PREFETCH) && !pf_q) || ((state_q == ST_SHIFT) && rd_req_q);
        bit_start = ((state_q == ST_PREFETCH) && pf_q)
                 || ((state_q == ST_SHIFT) && bit_last && !frame_last_bit);
        rd_addr   = (state_q == ST_IDLE) ? '0 : fetch_addr;
    end

    always_comb begin
        pf_d       = pf_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        latch_d    = latch_q;
        shift_d    = shift_q;
        next_d     = next_q;
        rd_req_d   = 1'b0;
        rd_vld_d   = rd_en;
        f_col_d    = f_col_q;
        f_row_d    = f_row_q;
        f_slot_d   = f_slot_q;

        if (rd_en) begin
            if (f_slot_q == 2'd2) begin
                f_slot_d = 2'd0;
                if (f_col_q == COL_LAST) begin
                    f_col_d = '0;
                    f_row_d = f_row_q + ADDR_W'(1);
                end else begin
                    f_col_d = f_col_q + ADDR_W'(1);
                end
            end else begin
                f_slot_d = f_slot_q + 2'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pf_d       = 1'b0;
                    bit_idx_d  = '0;
                    byte_idx_d = '0;
                    latch_d    = '0;
                    f_col_d    = '0;
                    f_row_d    = '0;
                    f_slot_d   = '0;
                end
            end
            ST_PREFETCH: begin
                pf_d = !pf_q;
                if (pf_q) shift_d = rd_data;
            end
            ST_SHIFT: begin
                if (rd_vld_q) next_d = rd_data;
                if (bit_last) begin
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        if (byte_idx_q != LAST_BYTE) begin
                            shift_d    = next_q;
                            byte_idx_d = byte_idx_q + ADDR_W'(1);
                        end
                    end else begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_idx_d = bit_idx_q + 3'd1;
                        // Fetch the following byte during bit 7 so it is ready at the byte boundary.
                        rd_req_d  = (bit_idx_q == 3'd6) && (byte_idx_q != LAST_BYTE);
                    end
                end
            end
            ST_LATCH: latch_d = latch_end ? '0 : latch_q + LCNT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pf_q       <= 1'b0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            latch_q    <= '0;
            shift_q    <= '0;
            next_q     <= '0;
            rd_req_q   <= 1'b0;
            rd_vld_q   <= 1'b0;
            f_col_q    <= '0;
            f_row_q    <= '0;
            f_slot_q   <= '0;
        end else begin
            pf_q       <= pf_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            latch_q    <= latch_d;
            shift_q    <= shift_d;
            next_q     <= next_d;
            rd_req_q   <= rd_req_d;
            rd_vld_q   <= rd_vld_d;
            f_col_q    <= f_col_d;
            f_row_q    <= f_row_d;
            f_slot_q   <= f_slot_d;
        end
    end

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Bench for ws2812_frame_driver: a 2x2 frame instance and a single-pixel instance, each fed by a
// 1-cycle-latency RAM model; waveforms are reduced to pulse edges and compared to a GRB bit-list model.
module tb_ws2812_frame_driver;
    import ws2812_frame_driver_pkg::*;

    localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int BITC  = 63;
    localparam int HI1   = 40;
    localparam int HI0   = 20;
    localparam int LATCH = 3000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, start1 = 1'b0;
    logic busy, done, rd_en, led_out;
    logic busy1, done1, rd_en1, led_out1;
    logic [15:0] rd_addr, rd_addr1;
    logic [7:0]  rd_data = 8'h00, rd_data1 = 8'h00;

    logic [7:0] mem[$];
    logic [7:0] mem1[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    ws2812_frame_driver #(.NUM_LEDS(NPIX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .led_out(led_out)
    );

    ws2812_frame_driver #(.NUM_LEDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .rd_addr(rd_addr1), .rd_en(rd_en1), .rd_data(rd_data1), .led_out(led_out1)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en)  rd_data  <= (int'(rd_addr)  < mem.size())  ? mem[rd_addr]   : 8'h00;
        if (rd_en1) rd_data1 <= (int'(rd_addr1) < mem1.size()) ? mem1[rd_addr1] : 8'h00;
    end

    int rise_q[$], fall_q[$], done_q[$], addr_q[$];
    int rise1_q[$], fall1_q[$], done1_q[$], addr1_q[$];
    logic led_prev = 1'b0, led1_prev = 1'b0;

    always @(negedge clk) begin
        led_prev  <= led_out;
        led1_prev <= led_out1;
        if (led_out && !led_prev)   rise_q.push_back(cyc);
        if (!led_out && led_prev)   fall_q.push_back(cyc);
        if (done)                   done_q.push_back(cyc);
        if (rd_en)                  addr_q.push_back(int'(rd_addr));
        if (led_out1 && !led1_prev) rise1_q.push_back(cyc);
        if (!led_out1 && led1_prev) fall1_q.push_back(cyc);
        if (done1)                  done1_q.push_back(cyc);
        if (rd_en1)                 addr1_q.push_back(int'(rd_addr1));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rise_q.delete();  fall_q.delete();  done_q.delete();  addr_q.delete();
        rise1_q.delete(); fall1_q.delete(); done1_q.delete(); addr1_q.delete();
    endtask

    task automatic fill_random();
        mem.delete();
        for (int i = 0; i < 3 * NPIX; i++) mem.push_back(8'($urandom));
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 10000 && !seen; i++) begin
            tick();
            seen = done;
        end
        check({tag, " done_seen"}, 32'(seen), 1);
    endtask

    // Reference: pixel order, GRB byte addresses and MSB-first bits, then ideal edge times.
    task automatic frame_check(input string tag, input int t0, input int nleds,
                               input logic [7:0] m[$], input int rq[$], input int fq[$],
                               input int dq[$], input int aq[$]);
        int bits[$];
        int addrs[$];
        int ord[3];
        int row, col, a, nb, exp_rise, exp_hi;
        logic [7:0] v;
        ord = '{1, 0, 2};
        for (int p = 0; p < nleds; p++) begin
            row = p / IMG_WIDTH;
            col = p % IMG_WIDTH;
`ifdef SERPENTINE_EN
            if (row % 2 == 1) col = IMG_WIDTH - 1 - col;
`endif
            for (int c = 0; c < 3; c++) begin
                a = 3 * (row * IMG_WIDTH + col) + ord[c];
                addrs.push_back(a);
                v = m[a];
                for (int b = 7; b >= 0; b--) bits.push_back(int'(v[b]));
            end
        end
        nb = bits.size();
        check({tag, " read_count"}, aq.size(), addrs.size());
        for (int i = 0; i < addrs.size() && i < aq.size(); i++) begin
            check($sformatf("%s rd_addr[%0d]", tag, i), aq[i], addrs[i]);
            if (aq[i] != addrs[i]) break;
        end
        check({tag, " pulse_count"}, rq.size(), nb);
        check({tag, " fall_count"}, fq.size(), nb);
        for (int k = 0; k < nb && k < rq.size() && k < fq.size(); k++) begin
            exp_rise = t0 + 3 + BITC * k;
            exp_hi   = bits[k] ? HI1 : HI0;
            check($sformatf("%s rise[%0d]", tag, k), rq[k], exp_rise);
            check($sformatf("%s high[%0d]", tag, k), fq[k] - rq[k], exp_hi);
            if (rq[k] != exp_rise || fq[k] - rq[k] != exp_hi) break;
        end
        check({tag, " done_count"}, dq.size(), 1);
        if (dq.size() > 0) check({tag, " done_cycle"}, dq[0], t0 + 3 + BITC * nb + LATCH - 1);
    endtask

    int t0;
    int guard;

    initial begin
        mem.delete();
        for (int i = 0; i < 3 * NPIX; i++) mem.push_back(8'(i));
        mem1 = '{8'h00, 8'hFF, 8'h80};

        repeat (3) tick();
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset rd_en", 32'(rd_en), 0);
        check("reset rd_addr", 32'(rd_addr), 0);
        check("reset led_out", 32'(led_out), 0);
        rst_n = 1'b1;
        tick();
        check("idle busy", 32'(busy), 0);

        // Frame A (bytes = address) plus single pixel; start during SHIFT and on done ignored.
        clear_mon();
        t0 = cyc;
        start = 1'b1; start1 = 1'b1;
        tick();
        start = 1'b0; start1 = 1'b0;
        check("A busy_after_start", 32'(busy), 1);
        check("A prefetch rd_en", 32'(rd_en), 1);
        check("A prefetch rd_addr", 32'(rd_addr), 1);
        check("A prefetch led", 32'(led_out), 0);
        repeat (500) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("A");
        check("A busy_on_done", 32'(busy), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("A busy_after_done", 32'(busy), 0);
        repeat (10) tick();
        check("A still_idle", 32'(busy), 0);
        frame_check("A", t0, NPIX, mem, rise_q, fall_q, done_q, addr_q);
        frame_check("P1", t0, 1, mem1, rise1_q, fall1_q, done1_q, addr1_q);

        // Frames B and C back to back, random contents.
        fill_random();
        clear_mon();
        t0 = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("B");
        frame_check("B", t0, NPIX, mem, rise_q, fall_q, done_q, addr_q);
        clear_mon();
        tick();
        t0 = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("C");
        frame_check("C", t0, NPIX, mem, rise_q, fall_q, done_q, addr_q);

        // Frame D abandoned by reset at bit 30, then full frame E.
        fill_random();
        repeat (3) tick();
        clear_mon();
        t0 = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (cyc < t0 + 3 + BITC * 30 && guard < 3000) begin
            tick();
            guard++;
        end
        check("D led_at_bit30", 32'(led_out), 1);
        rst_n = 1'b0;
        tick();
        check("D reset led", 32'(led_out), 0);
        check("D reset busy", 32'(busy), 0);
        tick();
        rst_n = 1'b1;
        repeat (100) tick();
        check("D no_done", done_q.size(), 0);
        check("D idle rd_en", 32'(rd_en), 0);

        clear_mon();
        t0 = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("E");
        frame_check("E", t0, NPIX, mem, rise_q, fall_q, done_q, addr_q);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
